// File: rtl/uart_tx_fifo_if.sv
// Host-side word handshake for uart_tx_fifo: the host drives words in,
// the transmitter drives back whether its FIFO has room for another.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data_in, data_valid, input  data_ready);
  modport slave  (input  data_in, data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO, runtime baud divisor and back-to-back framing.
// Define UART_TX_PARITY_EN to add a parity bit (sense from parity_odd) to every frame.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DIV_W-1:0]                    baud_div,
  input  logic                                parity_odd,
  uart_tx_fifo_if.slave                       host,
  output logic                                tx_line,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int BC_W  = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  wire unused_parity_odd = parity_odd;
`endif

  // FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 push, pop, full, empty;
  logic [DATA_BITS-1:0] head;

  assign full            = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign empty           = (fifo_count == '0);
  assign host.data_ready = !full;
  assign push            = host.data_valid && !full;
  assign head            = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host.data_in;
  end

  // Frame FSM
  state_t               state, state_n;
  logic [DIV_W-1:0]     baud_cnt, baud_cnt_n, div, div_n, div_clamp;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bit, par_bit_n;
  logic                 tick, tx_n;

  assign div_clamp = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign tick      = (baud_cnt == div - 1'b1);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + 1'b1;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    div_n      = div;
    par_bit_n  = par_bit;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_n   = head;
          div_n     = div_clamp;
          par_bit_n = ^head ^ parity_odd;
          bit_cnt_n = '0;
          state_n   = START;
        end
      end
      START: if (tick) begin
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
        state_n    = DATA;
      end
      DATA: if (tick) begin
        baud_cnt_n = '0;
        shift_n    = shift >> 1;
        if (bit_cnt == BC_W'(DATA_BITS-1)) begin
          bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
          state_n   = PARITY;
`else
          state_n   = STOP;
`endif
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
        state_n    = STOP;
      end
`endif
      STOP: if (tick) begin
        baud_cnt_n = '0;
        if (bit_cnt == BC_W'(STOP_BITS-1)) begin
          // Pop straight into START so consecutive frames have no idle gap
          if (!empty) begin
            pop       = 1'b1;
            shift_n   = head;
            div_n     = div_clamp;
            par_bit_n = ^head ^ parity_odd;
            bit_cnt_n = '0;
            state_n   = START;
          end else begin
            state_n   = IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // tx_line is registered, so it is driven from the state being entered
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_bit_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div      <= DIV_W'(2);
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      div      <= div_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par_bit  <= par_bit_n;
      tx_line  <= tx_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8N1-shaped instance plus a 7-data/2-stop instance.
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic        parity_odd = 1'b0;
  logic        tx8, busy8, tx7, busy7;
  logic [2:0]  cnt8, cnt7;
  int          checks = 0;
  int          passed = 0;

  uart_tx_fifo_if #(.DATA_BITS(8)) bus8 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) bus7 ();

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_odd(parity_odd),
    .host(bus8), .tx_line(tx8), .busy(busy8), .fifo_count(cnt8));

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(16)) dut7 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_odd(parity_odd),
    .host(bus7), .tx_line(tx7), .busy(busy7), .fifo_count(cnt7));

  always #5 clk = ~clk;

  task automatic push_word(input int sel, input logic [8:0] d);
    @(negedge clk);
    if (sel == 0) begin bus8.data_in = d[7:0]; bus8.data_valid = 1'b1; end
    else          begin bus7.data_in = d[6:0]; bus7.data_valid = 1'b1; end
    @(negedge clk);
    bus8.data_valid = 1'b0;
    bus7.data_valid = 1'b0;
  endtask

  // Samples every clock of one frame starting at the next falling edge.
  task automatic check_frame(input int sel, input logic [8:0] d, input int nb, input int ns,
                             input int dv, input logic odd, input string nm);
    logic b[16];
    int   n, bad, at;
    logic t, bz, ge, gt, gb;
    n = 0; bad = 0; at = 0; ge = 0; gt = 0; gb = 0;
    b[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin b[n] = d[i]; n++; end
`ifdef UART_TX_PARITY_EN
    begin
      logic p;
      p = odd;
      for (int i = 0; i < nb; i++) p = p ^ d[i];
      b[n] = p; n++;
    end
`endif
    for (int i = 0; i < ns; i++) begin b[n] = 1'b1; n++; end
    for (int k = 0; k < n*dv; k++) begin
      @(negedge clk);
      t  = (sel != 0) ? tx7 : tx8;
      bz = (sel != 0) ? busy7 : busy8;
      if (bad == 0 && (t !== b[k/dv] || bz !== 1'b1)) begin
        bad = 1; at = k; gt = t; gb = bz; ge = b[k/dv];
      end
    end
    checks++;
    if (bad != 0)
      $display("FAIL %s: clock %0d of frame got tx=%b busy=%b, expected tx=%b busy=1 (odd=%b)",
               nm, at, gt, gb, ge, odd);
    else passed++;
  endtask

  task automatic idle_check(input int sel, input string nm);
    logic t, bz;
    @(negedge clk);
    t  = (sel != 0) ? tx7 : tx8;
    bz = (sel != 0) ? busy7 : busy8;
    checks++;
    if (t !== 1'b1 || bz !== 1'b0)
      $display("FAIL %s: got tx=%b busy=%b, expected tx=1 busy=0", nm, t, bz);
    else passed++;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tx8 !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx8); else passed++;
    checks++; if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy8); else passed++;
    checks++; if (cnt8 !== 3'd0) $display("FAIL reset_count: got %0d expected 0", cnt8); else passed++;
    checks++; if (bus8.data_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus8.data_ready); else passed++;
    checks++; if (tx7 !== 1'b1) $display("FAIL reset_tx7: got %b expected 1", tx7); else passed++;
  endtask

  task automatic test_single;
    baud_div = 16'd4;
    push_word(0, 9'h0A5);
    check_frame(0, 9'h0A5, 8, 1, 4, parity_odd, "single_a5");
    idle_check(0, "single_idle");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    baud_div = 16'd4;
    parity_odd = 1'b0;
    push_word(0, 9'h0A5);
    check_frame(0, 9'h0A5, 8, 1, 4, 1'b0, "parity_even");
    idle_check(0, "parity_even_idle");
    parity_odd = 1'b1;
    push_word(0, 9'h0A5);
    check_frame(0, 9'h0A5, 8, 1, 4, 1'b1, "parity_odd");
    idle_check(0, "parity_odd_idle");
    parity_odd = 1'b0;
  endtask
`endif

  task automatic test_back_to_back;
    logic [7:0] w [6];
    int         full_low, ready_err, accepted;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h3C; w[3] = 8'h81; w[4] = 8'hF0; w[5] = 8'h5A;
    full_low = 0; ready_err = 0; accepted = 0;
    baud_div = 16'd2;
    @(negedge clk);
    fork
      begin
        logic r;
        int   guard;
        guard = 0;
        bus8.data_in = w[0]; bus8.data_valid = 1'b1;
        while (accepted < 6 && guard < 200) begin
          r = bus8.data_ready;
          @(posedge clk);
          if (r) accepted++;
          @(negedge clk);
          guard++;
          if (cnt8 == 3'd4 && bus8.data_ready === 1'b0) full_low = 1;
          if (bus8.data_ready !== (cnt8 != 3'd4)) ready_err++;
          if (accepted < 6) bus8.data_in = w[accepted];
          else              bus8.data_valid = 1'b0;
        end
        bus8.data_valid = 1'b0;
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 6; i++)
          check_frame(0, {1'b0, w[i]}, 8, 1, 2, parity_odd, $sformatf("b2b_word%0d", i));
      end
    join
    checks++;
    if (full_low == 0) $display("FAIL b2b_full: data_ready never low at fifo_count=4 (got %0d, expected 1)", full_low);
    else passed++;
    checks++;
    if (ready_err != 0 || accepted != 6)
      $display("FAIL b2b_ready: ready errors %0d accepted %0d, expected 0 and 6", ready_err, accepted);
    else passed++;
    idle_check(0, "b2b_idle");
  endtask

  task automatic test_baud_change;
    baud_div = 16'd4;
    push_word(0, 9'h0A5);
    fork
      begin
        push_word(0, 9'h03C);
        repeat (10) @(negedge clk);
        baud_div = 16'd8;
      end
      begin
        check_frame(0, 9'h0A5, 8, 1, 4, parity_odd, "baud_keep4");
        check_frame(0, 9'h03C, 8, 1, 8, parity_odd, "baud_next8");
      end
    join
    idle_check(0, "baud_idle");
    baud_div = 16'd0;
    push_word(0, 9'h096);
    check_frame(0, 9'h096, 8, 1, 2, parity_odd, "baud_zero");
    idle_check(0, "baud_zero_idle");
    baud_div = 16'd4;
  endtask

  task automatic test_reset_mid;
    int bad;
    baud_div = 16'd4;
    push_word(0, 9'h0F1);
    push_word(0, 9'h0F2);
    push_word(0, 9'h0F3);
    push_word(0, 9'h0F4);
    repeat (6) @(negedge clk);
    checks++;
    if (cnt8 !== 3'd3 || busy8 !== 1'b1)
      $display("FAIL rstmid_pre: count=%0d busy=%b, expected 3 and 1", cnt8, busy8);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (tx8 !== 1'b1) $display("FAIL rstmid_tx: got %b expected 1", tx8); else passed++;
    checks++; if (cnt8 !== 3'd0) $display("FAIL rstmid_count: got %0d expected 0", cnt8); else passed++;
    checks++; if (busy8 !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy8); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || cnt8 !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL rstmid_quiet: %0d active clocks after reset, expected 0", bad);
    else passed++;
    push_word(0, 9'h0C3);
    check_frame(0, 9'h0C3, 8, 1, 4, parity_odd, "rstmid_recover");
  endtask

  task automatic test_frame_shape;
    baud_div = 16'd4;
    push_word(1, 9'h055);
    check_frame(1, 9'h055, 7, 2, 4, parity_odd, "shape_7d2s");
    idle_check(1, "shape_idle");
  endtask

  initial begin
    bus8.data_in = '0; bus8.data_valid = 1'b0;
    bus7.data_in = '0; bus7.data_valid = 1'b0;
    test_reset();
    test_single();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_baud_change();
    test_reset_mid();
    test_frame_shape();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
